morse_sequencer: RTL and testbench
==================================

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter MAX_SYMBOLS, default 8: maximum dots/dashes per character.
REQ-002 SHALL have parameter UNIT_W, default 24: width of the dot-period cycle count.
REQ-003 SHALL have parameter LETTER_GAP, default 3: off units after a character's last symbol.
REQ-004 SHALL have parameter WORD_GAP, default 7: total off units between words.
REQ-005 SHALL have port clk_24, input, 1: 24 MHz clock.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port char_valid, input, 1: character bundle offered.
REQ-008 SHALL have port char_ready, output, 1: sequencer can accept a bundle.
REQ-009 SHALL have port char_data, input, 7: ASCII code.
REQ-010 SHALL have port code_bits, input, MAX_SYMBOLS: symbol i, 1=dash, 0=dot, bit 0 sent first.
REQ-011 SHALL have port code_len, input, $clog2(MAX_SYMBOLS+1): symbol count.
REQ-012 SHALL have port dot_cycles, input, UNIT_W: clk_24 cycles per unit.
REQ-013 SHALL have port abort, input, 1: drop the current character.
REQ-014 SHALL have port key, output, 1: Morse on/off state.
REQ-015 SHALL have port busy, output, 1: a character is in progress.

Function
REQ-016 SHALL accept a bundle on a cycle where char_valid and char_ready are both high.
REQ-017 SHALL latch char_data, code_bits, code_len and dot_cycles on accept.
REQ-018 SHALL treat a latched dot_cycles of 0 as 1.
REQ-019 SHALL drive char_ready = (state==IDLE) and rst_n, combinationally from state.
REQ-020 SHALL use states IDLE, MARK, SPACE and GAP; busy = state!=IDLE.
REQ-021 SHALL restart the unit timer on accept and on every state change.
REQ-022 SHALL have the unit timer emit a tick when the count reaches latched dot_cycles-1, then wrap to 0.
REQ-023 On accept of a non-space character with code_len>0, SHALL enter MARK on the next cycle.
REQ-024 SHALL raise key on the cycle MARK is entered.
REQ-025 SHALL hold key high in MARK for 1 unit (dot) or 3 units (dash).
REQ-026 Leaving MARK with symbols remaining, SHALL go to SPACE for 1 unit with key low.
REQ-027 Leaving MARK after the last symbol, SHALL go to GAP for LETTER_GAP units.
REQ-028 On accept of char_data 0x20, SHALL enter GAP for WORD_GAP-LETTER_GAP units with key low.
REQ-029 On accept of code_len 0 for a non-space character, SHALL return to IDLE next cycle with key low and no gap.
REQ-030 SHALL saturate code_len values above MAX_SYMBOLS to MAX_SYMBOLS.
REQ-031 At GAP expiry SHALL enter IDLE; char_ready is high in that IDLE cycle, so back-to-back characters incur one idle cycle.
REQ-032 When abort is high, SHALL force state IDLE and key 0 on the next cycle, from any state.
REQ-033 SHALL ignore char_valid while abort is high.
REQ-034 SHALL leave bundle inputs changing mid-character without effect.

Reset
REQ-035 SHALL reset key=0, busy=0, state=IDLE, timer=0 and symbol index=0 while rst_n is low; reset has priority over abort and accept.
REQ-036 SHALL force key low on the cycle after rst_n is asserted mid-MARK; no accept occurs during reset.

Configuration
REQ-037 With MORSE_ECHO_EN defined, SHALL add outputs echo_valid (1) and echo_data (8).
REQ-038 With MORSE_ECHO_EN defined, echo_valid SHALL pulse for exactly one cycle, the cycle after each accept, with echo_data={1'b0,char_data}, for UART debug echo.
REQ-039 With MORSE_ECHO_EN defined, echo_valid and echo_data SHALL reset to 0.
REQ-040 Without MORSE_ECHO_EN, the echo ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-041 SHALL place the state enum, ASCII_SPACE=7'h20, DOT_UNITS=1, DASH_UNITS=3 and SYMBOL_GAP=1 in shared package morse_pkg.
REQ-042 SHALL implement the unit timer as sub-module morse_unit_timer (inputs clk_24, rst_n, restart, period; output tick).
REQ-043 The ASCII-to-code lookup SHALL be external; it drives code_bits and code_len from char_data.

Verification
REQ-044 'E' (code_len=1, bits=0), dot_cycles=4 -> key high 4 cycles, low 12, char_ready high at cycle 17.
REQ-045 'A' (len=2, bits=2'b10), dot_cycles=2 -> key high 2, low 2, high 6, low 6, then IDLE.
REQ-046 Space 0x20, dot_cycles=3 -> key stays low, busy high 12 cycles, then IDLE.
REQ-047 abort asserted at cycle 5 of a dash (dot_cycles=10) -> key 0 and char_ready 1 at cycle 6; a new char is accepted cleanly.
REQ-048 rst_n low mid-MARK with char_valid held high -> key 0 next cycle; no accept until rst_n is high; echo_valid stays 0.
REQ-049 code_len=0 and dot_cycles=0 cases -> immediate return to IDLE, and 1-cycle units respectively; echo_data=0x45 one cycle after accepting 'E' when MORSE_ECHO_EN is defined.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sequencer slice.
//   state_e     : sequencer FSM states (IDLE, MARK, SPACE, GAP)
//   ASCII_SPACE : character code that requests a word gap instead of symbols
//   DOT_UNITS / DASH_UNITS / SYMBOL_GAP : on/off durations in dot units
//   UNITS_W     : width of the per-state unit counter
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam int         DOT_UNITS   = 1;
    localparam int         DASH_UNITS  = 3;
    localparam int         SYMBOL_GAP  = 1;
    localparam int         UNITS_W     = 8;

endpackage

// File: rtl/morse_if.sv
// Character bundle channel into the Morse sequencer.
// Handshake: the master holds char_valid and the bundle fields stable until a
// rising clock edge where char_valid and char_ready are both high; that edge is
// the single transfer. char_ready may depend on the slave's state only, never
// on char_valid. Fields outside a transfer are don't-care.
//   char_valid : bundle offered (master)
//   char_ready : slave can accept (slave)
//   char_data  : 7-bit ASCII code
//   code_bits  : symbol i, 1=dash, 0=dot, bit 0 sent first
//   code_len   : number of symbols
//   dot_cycles : clock cycles per dot unit
interface morse_if #(
    parameter int MAX_SYMBOLS = 8,
    parameter int UNIT_W      = 24
) ();
    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);

    logic                   char_valid;
    logic                   char_ready;
    logic [6:0]             char_data;
    logic [MAX_SYMBOLS-1:0] code_bits;
    logic [LEN_W-1:0]       code_len;
    logic [UNIT_W-1:0]      dot_cycles;

    modport master (
        output char_valid, char_data, code_bits, code_len, dot_cycles,
        input  char_ready
    );

    modport slave (
        input  char_valid, char_data, code_bits, code_len, dot_cycles,
        output char_ready
    );
endinterface

// File: rtl/morse_unit_timer.sv
// Dot-unit timer. Counts clk_24 cycles from 0 to period-1 and raises tick on
// the last count, then wraps to 0. restart forces the count back to 0 on the
// next edge so every new state starts with a full unit.
//   clk_24  : clock
//   rst_n   : synchronous active-low reset
//   restart : zero the count on the next edge
//   period  : cycles per unit (caller guarantees nonzero)
//   tick    : high on the final cycle of each unit
module morse_unit_timer #(
    parameter int UNIT_W = 24
) (
    input  logic              clk_24,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [UNIT_W-1:0] period,
    output logic              tick
);
    logic [UNIT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == period - UNIT_W'(1));

    always_comb begin
        cnt_d = cnt_q + UNIT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_24) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/morse_sequencer.sv
// Morse keying sequencer. Accepts one character bundle (already looked up into
// dot/dash code bits) and plays it on key: each symbol as a mark, separated by
// one-unit spaces, followed by a letter gap. An ASCII space plays only the
// extra off-time that turns a letter gap into a word gap.
//   clk_24, rst_n : clock, synchronous active-low reset
//   bus           : morse_if.slave character bundle channel
//   abort         : drop the current character, back to IDLE next cycle
//   key           : Morse on/off output
//   busy          : a character is in progress
//   state_dbg     : current FSM state
// Optional build macro MORSE_ECHO_EN adds echo_valid/echo_data, a one-cycle
// pulse carrying {1'b0, char_data} the cycle after each accept.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 8,
    parameter int UNIT_W      = 24,
    parameter int LETTER_GAP  = 3,
    parameter int WORD_GAP    = 7
) (
    input  logic   clk_24,
    input  logic   rst_n,
    morse_if.slave bus,
    input  logic   abort,
    output logic   key,
    output logic   busy,
    output state_e state_dbg
`ifdef MORSE_ECHO_EN
    ,
    output logic       echo_valid,
    output logic [7:0] echo_data
`endif
);
    localparam int               LEN_W   = $clog2(MAX_SYMBOLS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMBOLS);

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       sym_q, sym_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [MAX_SYMBOLS-1:0] bits_q, bits_d;
    logic [UNIT_W-1:0]      period_q, period_d;
    logic [UNITS_W-1:0]     units_q, units_d;
    logic                   space_q, space_d;
    logic                   key_q, key_d;

    logic                   accept;
    logic                   restart;
    logic                   tick;
    logic [LEN_W-1:0]       len_sat;
    logic [UNITS_W-1:0]     mark_units;
    logic [UNITS_W-1:0]     gap_units;

    assign bus.char_ready = (state_q == IDLE) && rst_n;
    assign accept         = bus.char_valid && bus.char_ready && !abort;
    assign len_sat        = (bus.code_len > MAX_LEN) ? MAX_LEN : bus.code_len;
    // bits_q is shifted right after each symbol, so bit 0 is always the current one.
    assign mark_units     = bits_q[0] ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
    assign gap_units      = space_q ? UNITS_W'(WORD_GAP - LETTER_GAP) : UNITS_W'(LETTER_GAP);

    assign key       = key_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    morse_unit_timer #(.UNIT_W(UNIT_W)) u_timer (
        .clk_24  (clk_24),
        .rst_n   (rst_n),
        .restart (restart),
        .period  (period_q),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        len_d    = len_q;
        bits_d   = bits_q;
        period_d = period_q;
        units_d  = units_q;
        space_d  = space_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    bits_d   = bus.code_bits;
                    len_d    = len_sat;
                    period_d = (bus.dot_cycles == '0) ? UNIT_W'(1) : bus.dot_cycles;
                    sym_d    = '0;
                    units_d  = '0;
                    space_d  = (bus.char_data == ASCII_SPACE);
                    if (bus.char_data == ASCII_SPACE) begin
                        state_d = GAP;
                    end else if (len_sat != '0) begin
                        state_d = MARK;
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    if (units_q == mark_units - UNITS_W'(1)) begin
                        units_d = '0;
                        sym_d   = sym_q + LEN_W'(1);
                        bits_d  = bits_q >> 1;
                        state_d = (sym_q + LEN_W'(1) == len_q) ? GAP : SPACE;
                    end else begin
                        units_d = units_q + UNITS_W'(1);
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (units_q == UNITS_W'(SYMBOL_GAP - 1)) begin
                        units_d = '0;
                        state_d = MARK;
                    end else begin
                        units_d = units_q + UNITS_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (units_q == gap_units - UNITS_W'(1)) begin
                        units_d = '0;
                        state_d = IDLE;
                    end else begin
                        units_d = units_q + UNITS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            sym_d   = '0;
            units_d = '0;
        end

        restart = accept || (state_d != state_q);
        // Registered so key rises together with the first MARK cycle.
        key_d   = (state_d == MARK);
    end

    always_ff @(posedge clk_24) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sym_q    <= '0;
            len_q    <= '0;
            bits_q   <= '0;
            period_q <= '0;
            units_q  <= '0;
            space_q  <= 1'b0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sym_q    <= sym_d;
            len_q    <= len_d;
            bits_q   <= bits_d;
            period_q <= period_d;
            units_q  <= units_d;
            space_q  <= space_d;
            key_q    <= key_d;
        end
    end

`ifdef MORSE_ECHO_EN
    logic       echo_valid_q, echo_valid_d;
    logic [7:0] echo_data_q, echo_data_d;

    always_comb begin
        echo_valid_d = accept;
        echo_data_d  = accept ? {1'b0, bus.char_data} : echo_data_q;
    end

    always_ff @(posedge clk_24) begin
        if (!rst_n) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'h00;
        end else begin
            echo_valid_q <= echo_valid_d;
            echo_data_q  <= echo_data_d;
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
`endif
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: a table of character bundles with
// hand-derived key traces, plus reset, abort and mid-character reset sequences.
// Build with MORSE_ECHO_EN defined to also check the echo outputs.
module tb_morse_sequencer;
    import morse_pkg::*;

    logic   clk_24;
    logic   rst_n;
    logic   abort;
    logic   key;
    logic   busy;
    state_e state_dbg;
`ifdef MORSE_ECHO_EN
    logic       echo_valid;
    logic [7:0] echo_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    morse_if #(.MAX_SYMBOLS(8), .UNIT_W(24)) bus ();

    morse_sequencer #(
        .MAX_SYMBOLS (8),
        .UNIT_W      (24),
        .LETTER_GAP  (3),
        .WORD_GAP    (7)
    ) dut (
        .clk_24    (clk_24),
        .rst_n     (rst_n),
        .bus       (bus),
        .abort     (abort),
        .key       (key),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef MORSE_ECHO_EN
        ,
        .echo_valid (echo_valid),
        .echo_data  (echo_data)
`endif
    );

    // ---------------- clock ----------------
    initial clk_24 = 1'b0;
    always #20 clk_24 = ~clk_24;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  ch;
        logic [7:0]  bits;
        logic [3:0]  len;
        logic [23:0] dot;
        logic [63:0] exp_key;   // bit c = key in cycle c+1 after accept
        int          exp_busy;  // busy cycles; also index of first ready cycle
    } vec_t;

    vec_t vecs[9];

    // ---------------- driver ----------------
    // Offers a bundle and returns at the negedge of the first cycle after accept
    // with char_valid low and the bundle fields scrambled.
    task automatic accept_bundle(input logic [6:0] ch, input logic [7:0] bits,
                                 input logic [3:0] len, input logic [23:0] dot);
        int waited = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = ch;
        bus.code_bits  = bits;
        bus.code_len   = len;
        bus.dot_cycles = dot;
        while (!bus.char_ready && waited < 100) begin
            @(negedge clk_24);
            waited++;
        end
        if (waited >= 100) begin
            check("accept_timeout", 64'(bus.char_ready), 64'd1);
        end
        @(posedge clk_24);
        @(negedge clk_24);
        bus.char_valid = 1'b0;
        bus.char_data  = 7'($urandom);
        bus.code_bits  = 8'($urandom);
        bus.code_len   = 4'($urandom);
        bus.dot_cycles = 24'($urandom_range(0, 7));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [63:0] trace;
        int          busy_cnt;
        int          ready_idx;
        trace     = '0;
        busy_cnt  = 0;
        ready_idx = -1;
        accept_bundle(v.ch, v.bits, v.len, v.dot);
`ifdef MORSE_ECHO_EN
        check({name, "_echo_valid"}, 64'(echo_valid), 64'd1);
        check({name, "_echo_data"}, 64'(echo_data), 64'({1'b0, v.ch}));
`endif
        for (int c = 0; c < 64; c++) begin
            trace[c] = key;
            if (busy) busy_cnt++;
            if (bus.char_ready && ready_idx < 0) ready_idx = c;
`ifdef MORSE_ECHO_EN
            if (c == 1) check({name, "_echo_pulse_end"}, 64'(echo_valid), 64'd0);
`endif
            @(negedge clk_24);
        end
        check({name, "_key_trace"}, trace, v.exp_key);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
        check({name, "_ready_cycle"}, 64'(ready_idx), 64'(v.exp_busy));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{7'h45, 8'h00, 4'd1,  24'd4, 64'h000F, 16}; // E
        vecs[1] = '{7'h41, 8'h02, 4'd2,  24'd2, 64'h03F3, 16}; // A .-
        vecs[2] = '{7'h20, 8'h00, 4'd0,  24'd3, 64'h0000, 12}; // word space
        vecs[3] = '{7'h54, 8'h01, 4'd1,  24'd1, 64'h0007, 6};  // T -
        vecs[4] = '{7'h45, 8'h00, 4'd1,  24'd0, 64'h0001, 4};  // E, dot_cycles 0
        vecs[5] = '{7'h4E, 8'h01, 4'd2,  24'd1, 64'h0017, 8};  // N -.
        vecs[6] = '{7'h58, 8'hFF, 4'd0,  24'd5, 64'h0000, 0};  // code_len 0
        vecs[7] = '{7'h48, 8'h00, 4'd15, 24'd1, 64'h5555, 18}; // len saturates to 8
        vecs[8] = '{7'h20, 8'hFF, 4'd3,  24'd0, 64'h0000, 4};  // space, dot 0

        rst_n          = 1'b0;
        abort          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.code_bits  = '0;
        bus.code_len   = '0;
        bus.dot_cycles = '0;

        // reset state
        repeat (3) @(posedge clk_24);
        @(negedge clk_24);
        check("rst_key", 64'(key), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(bus.char_ready), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
`ifdef MORSE_ECHO_EN
        check("rst_echo_valid", 64'(echo_valid), 64'd0);
        check("rst_echo_data", 64'(echo_data), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk_24);
        check("post_rst_ready", 64'(bus.char_ready), 64'd1);

        // table-driven characters
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // abort in cycle 5 of a dash, with a bundle offered during abort
        accept_bundle(7'h54, 8'h01, 4'd1, 24'd10);
        repeat (4) @(negedge clk_24);
        check("abort_pre_key", 64'(key), 64'd1);
        abort          = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = 7'h45;
        bus.code_bits  = 8'h00;
        bus.code_len   = 4'd1;
        bus.dot_cycles = 24'd1;
        @(negedge clk_24);
        check("abort_key", 64'(key), 64'd0);
        check("abort_ready", 64'(bus.char_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk_24);
        check("abort_blocks_accept", 64'(busy), 64'd0);
`ifdef MORSE_ECHO_EN
        check("abort_no_echo", 64'(echo_valid), 64'd0);
`endif
        abort          = 1'b0;
        bus.char_valid = 1'b0;
        run_vec('{7'h45, 8'h00, 4'd1, 24'd1, 64'h0001, 4}, "after_abort");

        // reset in the middle of a mark with a bundle held valid
        accept_bundle(7'h54, 8'h01, 4'd1, 24'd10);
        repeat (2) @(negedge clk_24);
        check("midrst_pre_key", 64'(key), 64'd1);
        rst_n          = 1'b0;
        bus.char_valid = 1'b1;
        bus.char_data  = 7'h45;
        bus.code_bits  = 8'h00;
        bus.code_len   = 4'd1;
        bus.dot_cycles = 24'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_24);
            check($sformatf("midrst_key_%0d", c), 64'(key), 64'd0);
            check($sformatf("midrst_busy_%0d", c), 64'(busy), 64'd0);
            check($sformatf("midrst_ready_%0d", c), 64'(bus.char_ready), 64'd0);
`ifdef MORSE_ECHO_EN
            check($sformatf("midrst_echo_%0d", c), 64'(echo_valid), 64'd0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk_24);
        check("postrst_accept_key", 64'(key), 64'd1);
        check("postrst_accept_busy", 64'(busy), 64'd1);
`ifdef MORSE_ECHO_EN
        check("postrst_echo_data", 64'(echo_data), 64'h45);
`endif
        bus.char_valid = 1'b0;
        repeat (4) @(negedge clk_24);
        check("postrst_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
